byte_serial_adder: RTL and testbench
====================================

BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operands and carry-in are presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have ports a and b, input, 8*NBYTES bits each: unsigned operands.
REQ-007 The block SHALL have port c_in, input, 1 bit: carry into byte 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is held stable.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port sum, output, 8*NBYTES bits: the result bits.
REQ-011 The block SHALL have port c_out, output, 1 bit: carry out of the top byte.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL implement an FSM with three states: IDLE, ADD and DONE.
REQ-014 In IDLE the block SHALL drive in_ready=1; in ADD and DONE it SHALL drive in_ready=0.
REQ-015 An accept SHALL occur when in_valid and in_ready are both high at a clock edge.
- On accept the block latches a, b and c_in into internal registers.
- It clears the byte index to 0 and moves to ADD.
REQ-016 Each ADD cycle SHALL add one 8-bit slice.
- It computes operand bytes [idx] plus the carry register.
- It writes the 8-bit result into sum byte [idx] and the carry-out into the carry register.
- It increments idx by 1.
REQ-017 When idx==NBYTES-1 in ADD, the block SHALL move to DONE at that edge instead of incrementing idx.
REQ-018 out_valid SHALL rise exactly NBYTES rising edges after the accept edge and SHALL be high only in DONE.
REQ-019 In DONE, sum and c_out SHALL hold stable until out_ready is high at an edge; the block SHALL then return to IDLE.
REQ-020 The result SHALL equal (a+b+c_in) mod 2^(8*NBYTES), with c_out equal to bit 8*NBYTES of the full sum.
REQ-021 in_valid while busy SHALL be ignored: no latch and no state change.
- Input changes after accept SHALL NOT affect the result.
REQ-022 sum and c_out SHALL NOT be guaranteed valid outside DONE.
- They SHALL change only in ADD and on reset.
REQ-023 Minimum initiation interval SHALL be NBYTES+2 cycles: accept, NBYTES ADD cycles, one DONE cycle, then IDLE.
- A new accept is not allowed in the DONE-handshake cycle.
REQ-024 The block SHALL NOT produce combinational paths from in_valid to in_ready, nor from out_ready to out_valid.

Reset
REQ-025 Assertion of rst_n low SHALL immediately force the following, asynchronously:
- state=IDLE, idx=0 and the carry register to 0;
- sum=0, c_out=0, out_valid=0 and busy=0;
- in_ready=1.
REQ-026 A reset in the middle of ADD or DONE SHALL discard the operation.
- No out_valid pulse follows the reset.
- The first accept after rst_n rises SHALL behave as from power-up.
REQ-027 Reset release SHALL be synchronised externally; the block itself needs no release logic.

Structure
REQ-028 The shared package SHALL hold the FSM state encoding (IDLE=2'b00, ADD=2'b01, DONE=2'b10) and the BYTE_W=8 constant.
REQ-029 The byte-slice addition SHALL reuse the existing EightBitFullAdder block as the single sub-module, instantiated once.
- Its inputs are driven by a byte multiplexer indexed by idx.
REQ-030 idx SHALL be $clog2(NBYTES) bits wide.

Verification (NBYTES=4)
REQ-031 Carry chain: accept a=0xFFFFFFFF, b=0x00000001, c_in=0 -> out_valid 4 edges later with sum=0x00000000, c_out=1.
REQ-032 Carry-in only: accept a=0x12345678, b=0x00000000, c_in=1 -> sum=0x12345679, c_out=0.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, c_out and out_valid stable; in_ready stays 0; a pulse of in_valid with new operands is ignored.
REQ-034 Mid-op reset: pull rst_n low during the ADD cycle with idx=2 -> all outputs reset at once, in_ready=1, and no out_valid follows.
REQ-035 Random regression: 10,000 random (a, b, c_in) triples with random in_valid/out_ready gaps -> every result matches a+b+c_in, with no lost or duplicated transactions.
REQ-036 Limits: a=b=0xFFFFFFFF with c_in=1 -> sum=0xFFFFFFFF, c_out=1; zero operands with c_in=0 -> sum=0, c_out=0.

Source files
------------

// File: rtl/byte_serial_adder_pkg.sv
// Shared definitions for the byte-serial adder: FSM encoding and byte width.
package byte_serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/byte_serial_adder_fa8.sv
// EightBitFullAdder: one byte plus carry-in, producing a byte and a carry-out.
module EightBitFullAdder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] sum_o,
  output logic       c_o
);

  logic [8:0] total;

  assign total = {1'b0, a_i} + {1'b0, b_i} + {8'b0, c_i};
  assign sum_o = total[7:0];
  assign c_o   = total[8];

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-byte adder that reuses one 8-bit full adder over NBYTES cycles,
// with valid/ready handshakes on both the operand and result sides.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*NBYTES-1:0]      a,
  input  logic [8*NBYTES-1:0]      b,
  input  logic                     c_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*NBYTES-1:0]      sum,
  output logic                     c_out,
  output logic                     busy,
  output logic [1:0]               dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends combinationally on the partner's valid.
  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e state_q, state_d;

  logic [W-1:0]      a_q, b_q, sum_q, sum_d;
  logic              carry_q, c_out_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BYTE_W-1:0] a_byte, b_byte, fa_sum;
  logic              fa_co;
  logic              accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ADD;
      ADD:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Byte multiplexer feeding the shared adder, and the matching write-back slot.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    sum_d  = sum_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_byte = a_q[i*BYTE_W +: BYTE_W];
        b_byte = b_q[i*BYTE_W +: BYTE_W];
        sum_d[i*BYTE_W +: BYTE_W] = fa_sum;
      end
    end
  end

  EightBitFullAdder u_fa8 (
    .a_i   (a_byte),
    .b_i   (b_byte),
    .c_i   (carry_q),
    .sum_o (fa_sum),
    .c_o   (fa_co)
  );

  // c_out is kept apart from the running carry so it only moves during ADD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= c_in;
      idx_q   <= '0;
    end else if (state_q == ADD) begin
      sum_q   <= sum_d;
      carry_q <= fa_co;
      c_out_q <= fa_co;
      if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign sum         = sum_q;
  assign c_out       = c_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed and light random bench for byte_serial_adder with NBYTES=4.
module tb_byte_serial_adder;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          c_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          c_out;
  logic          busy;
  logic [1:0]    dbg_state;

  logic [W:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  byte_serial_adder #(.NBYTES(NBYTES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .c_out       (c_out),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present one operand set, wait for the result, hold it for
  // 'hold' cycles under backpressure, then complete the output handshake
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input int hold);
    int lat;
    logic [W:0] exp;
    logic [W-1:0] held_sum;
    logic held_c;
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb; c_in = tc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = tb ^ 32'h5A5A_A5A5; c_in = ~tc;
    lat = 1;
    while (!out_valid && lat <= 20) begin
      check("busy_during_add", busy, 1);
      @(posedge clk);
      #1;
      if (!out_valid) lat++;
    end
    check("latency", lat, NBYTES);
    exp = exp_q.pop_front();
    check("sum", sum, exp[W-1:0]);
    check("c_out", c_out, exp[W]);
    held_sum = sum;
    held_c   = c_out;
    for (int k = 0; k < hold; k++) begin
      if (k == 1) begin
        a = 32'hDEAD_BEEF; b = 32'h1111_1111; c_in = 1'b1; in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_out_valid", out_valid, 1);
      check("hold_sum", sum, held_sum);
      check("hold_c_out", c_out, held_c);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic push_exp(input logic [W-1:0] s, input logic c);
    exp_q.push_back({c, s});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   full;
    int           cnt;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_state", dbg_state, 2'b00);
    rst_n = 1'b1;

    push_exp(32'h0000_0000, 1'b1); run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    push_exp(32'h1234_5679, 1'b0); run_txn(32'h1234_5678, 32'h0000_0000, 1'b1, 0);
    push_exp(32'h1122_3344, 1'b0); run_txn(32'h0102_0304, 32'h1020_3040, 1'b0, 5);
    push_exp(32'hFFFF_FFFF, 1'b1); run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
    push_exp(32'h0000_0000, 1'b0); run_txn(32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    push_exp(32'h0001_0000, 1'b0); run_txn(32'h0000_FF00, 32'h0000_0100, 1'b0, 2);
    push_exp(32'h0000_0000, 1'b1); run_txn(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

    // reset while the third byte slice is being added
    @(negedge clk);
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("midreset_pre_state", dbg_state, 2'b01);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_sum", sum, 0);
    check("midreset_c_out", c_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midreset_no_out_valid", cnt, 0);
    push_exp(32'h0000_0003, 1'b0); run_txn(32'h0000_0001, 32'h0000_0001, 1'b1, 0);

    // random operands with random idle gaps and backpressure
    for (int t = 0; t < 200; t++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      push_exp(full[W-1:0], full[W]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(ra, rb, rc, $urandom_range(0, 3));
    end
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
